// File: rtl/soc_system_hps_fifo_buffer.sv
// Single-clock circular FIFO between the HPS writer and a fabric reader.
// Read latency is one cycle, and every status bit comes straight from a flop so the PIO capture logic sees clean edges.
module soc_system_hps_fifo_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic [$clog2(DEPTH):0]  level,
    input  logic                    clear_flags,
    output logic [7:0]              status
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [LW-1:0]         level_nxt;
    logic                  rd_acc, wr_acc, ovf_set, udf_set;
    logic                  full_q, af_q, empty_q, ae_q, ovf_q, udf_q, half_q;

    // When the FIFO is full, a write can still be taken if a read frees a slot on the same edge.
    assign rd_acc  = rd_en && (level != '0);
    assign wr_acc  = wr_en && ((level != LW'(DEPTH)) || rd_acc);
    assign ovf_set = wr_en && !wr_acc;
    assign udf_set = rd_en && !rd_acc;

    always_comb begin
        level_nxt = level;
        case ({wr_acc, rd_acc})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !reset)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            empty_q  <= 1'b1;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            half_q   <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            level <= level_nxt;

            // Flags are computed from the next-state level, so they move on the same edge as level.
            full_q  <= (level_nxt == LW'(DEPTH));
            af_q    <= (level_nxt >= LW'(AF_LEVEL));
            empty_q <= (level_nxt == '0);
            ae_q    <= (level_nxt <= LW'(AE_LEVEL));
            half_q  <= (level_nxt >= LW'(DEPTH / 2));

            // Sticky errors: a new error in the same cycle beats clear_flags.
            if (ovf_set)          ovf_q <= 1'b1;
            else if (clear_flags) ovf_q <= 1'b0;
            if (udf_set)          udf_q <= 1'b1;
            else if (clear_flags) udf_q <= 1'b0;
        end
    end

    assign status = {1'b0, half_q, udf_q, ovf_q, ae_q, empty_q, af_q, full_q};

endmodule

// File: tb/tb_soc_system_hps_fifo_buffer.sv
// Random and directed stimulus against a queue-based FIFO model; a negedge monitor scores read data, level and status.
module tb_soc_system_hps_fifo_buffer;
    localparam int DW = 32;
    localparam int D  = 16;
    localparam int AF = 14;
    localparam int AE = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0, rd_en = 1'b0, clear_flags = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [4:0]    level;
    logic [7:0]    status;

    soc_system_hps_fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .level(level),
        .clear_flags(clear_flags), .status(status)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue, sticky errors as plain bits.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_rd = '0;
    bit            m_ovf = 0, m_udf = 0, exp_valid = 0, mon_en = 0;
    int            n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] exp_status();
        int n = m_q.size();
        return {1'b0, n >= D/2, m_udf, m_ovf, n <= AE, n == 0, n >= AF, n == D};
    endfunction

    task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit c, input bit rst);
        bit ra, wa;
        wr_en = w; wr_data = d; rd_en = r; clear_flags = c; reset = rst;
        @(posedge clk);
        if (rst) begin
            m_q.delete(); m_ovf = 0; m_udf = 0; exp_valid = 0; last_rd = '0;
        end else begin
            ra = r && m_q.size() != 0;
            wa = w && (m_q.size() != D || ra);
            exp_valid = ra;
            if (ra) exp_q.push_back(m_q.pop_front());
            if (wa) m_q.push_back(d);
            if (w && !wa) m_ovf = 1; else if (c) m_ovf = 0;
            if (r && !ra) m_udf = 1; else if (c) m_udf = 0;
        end
        #1;
        wr_en = 0; rd_en = 0; clear_flags = 0; reset = 0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("rd_valid", rd_valid, exp_valid);
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL rd_data: unexpected strobe data %0h at %0t", rd_data, $time);
                end else begin
                    last_rd = exp_q.pop_front();
                    chk("rd_data", rd_data, last_rd);
                end
            end else begin
                chk("rd_hold", rd_data, last_rd);
            end
            chk("level", level, m_q.size());
            chk("status", status, exp_status());
        end
    end

    initial begin
        cyc(0, 0, 0, 0, 1);
        cyc(1, 32'h55, 1, 1, 1);
        mon_en = 1;
        chk("reset_level", level, 0);
        chk("reset_status", status, 8'h0C);

        for (int i = 0; i < 16; i++) cyc(1, i, 0, 0, 0);
        chk("fill_level", level, 16);
        chk("fill_status", status, 8'h43);

        cyc(1, 32'hDEAD, 0, 0, 0);
        chk("ovf_set", status[4], 1);
        chk("ovf_level", level, 16);
        cyc(0, 0, 0, 1, 0);
        chk("ovf_clear", status[4], 0);

        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("drain_status", status, 8'h0C);

        cyc(0, 0, 1, 1, 0);
        chk("udf_set_wins", status[5], 1);
        chk("udf_no_valid", rd_valid, 0);

        cyc(0, 0, 0, 1, 0);
        cyc(1, 32'hA5A5, 1, 0, 0);
        chk("empty_rw_level", level, 1);
        chk("empty_rw_udf", status[5], 1);
        chk("empty_rw_valid", rd_valid, 0);
        cyc(0, 0, 1, 1, 0);

        for (int i = 0; i < 16; i++) cyc(1, 32'h100 + i, 0, 0, 0);
        cyc(1, 32'h200, 1, 0, 0);
        chk("full_rw_level", level, 16);
        chk("full_rw_no_ovf", status[4], 0);
        for (int i = 0; i < 17; i++) cyc(0, 0, 1, 1, 0);

        // Held at 2 so that almost_empty (level <= 2) holds for the whole pointer wrap.
        cyc(0, 0, 0, 1, 0);
        cyc(1, 32'h300, 0, 0, 0);
        cyc(1, 32'h301, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            cyc(1, 32'h302 + i, 1, 0, 0);
            chk("wrap_level", level, 2);
            chk("wrap_ae", status[3], 1);
        end
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);

        for (int i = 0; i < 9; i++) cyc(1, 32'h400 + i, 0, 0, 0);
        chk("pre_rst_level", level, 9);
        cyc(1, 32'h4FF, 1, 1, 1);
        chk("rst_level", level, 0);
        chk("rst_status", status, 8'h0C);
        cyc(0, 0, 1, 0, 0);
        chk("rst_udf", status[5], 1);
        chk("rst_udf_valid", rd_valid, 0);

        for (int i = 0; i < 900; i++) begin
            int mode = (i / 75) % 3;
            int wp = (mode == 0) ? 80 : (mode == 1) ? 25 : 55;
            int rp = (mode == 0) ? 25 : (mode == 1) ? 80 : 55;
            cyc($urandom_range(99) < wp, $urandom, $urandom_range(99) < rp,
                $urandom_range(7) == 0, $urandom_range(199) == 0);
        end

        cyc(0, 0, 0, 0, 0);
        @(negedge clk); #1;
        mon_en = 0;
        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
